// File: rtl/multilane_staged_mac.sv
// multilane_staged_mac: C_LANES signed (input x weight) products per beat, summed and
// accumulated over a packet; the packet total leaves as one AXI-Stream beat on TLAST.
// Two register stages (products, then accumulate/output), stalled as a unit by MO back-pressure.
// Optional build macro MAC_SATURATE_EN clamps the accumulator on signed overflow
// instead of wrapping.
module multilane_staged_mac #(
  parameter int unsigned C_DATA_WIDTH = 8,
  parameter int unsigned C_LANES      = 4,
  parameter int unsigned C_ACC_WIDTH  = 32,
  parameter int unsigned C_TID_WIDTH  = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  output logic                              SD_AXIS_TREADY,
  input  logic [C_LANES*2*C_DATA_WIDTH-1:0] SD_AXIS_TDATA,
  input  logic                              SD_AXIS_TLAST,
  input  logic                              SD_AXIS_TUSER,
  input  logic                              SD_AXIS_TVALID,
  input  logic [C_TID_WIDTH-1:0]            SD_AXIS_TID,
  output logic                              MO_AXIS_TVALID,
  output logic [C_ACC_WIDTH-1:0]            MO_AXIS_TDATA,
  output logic                              MO_AXIS_TLAST,
  input  logic                              MO_AXIS_TREADY,
  output logic [C_TID_WIDTH-1:0]            MO_AXIS_TID
);

  localparam int unsigned DW  = C_DATA_WIDTH;
  localparam int unsigned PW  = 2 * C_DATA_WIDTH;
  localparam int unsigned MSB = C_ACC_WIDTH - 1;

  logic                   rdy_q;
  logic                   adv;
  logic                   accept;
  logic [PW-1:0]          prod_c [C_LANES];
  logic [PW-1:0]          prod_q [C_LANES];
  logic                   v1;
  logic                   last1;
  logic                   user1;
  logic [C_TID_WIDTH-1:0] tid1;
  logic [C_ACC_WIDTH-1:0] acc_q;
  logic [C_ACC_WIDTH-1:0] sum_c;
  logic [C_ACC_WIDTH-1:0] acc_base_c;
  logic [C_ACC_WIDTH-1:0] acc_next_c;

  // Whole pipeline moves only when the output slot is free or being drained
  assign adv            = !(MO_AXIS_TVALID && !MO_AXIS_TREADY);
  assign SD_AXIS_TREADY = rdy_q && adv;
  assign accept         = SD_AXIS_TVALID && SD_AXIS_TREADY;

  // Exact signed lane products of the incoming beat
  always_comb begin
    for (int k = 0; k < int'(C_LANES); k++) begin
      prod_c[k] = PW'($signed(SD_AXIS_TDATA[2*k*DW + DW +: DW]))
                * PW'($signed(SD_AXIS_TDATA[2*k*DW +: DW]));
    end
  end

  // Stage 1: capture products and beat sideband
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_q <= 1'b0;
      v1    <= 1'b0;
      last1 <= 1'b0;
      user1 <= 1'b0;
      tid1  <= '0;
      for (int k = 0; k < int'(C_LANES); k++) prod_q[k] <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (adv) begin
        v1    <= accept;
        last1 <= SD_AXIS_TLAST;
        user1 <= SD_AXIS_TUSER;
        tid1  <= SD_AXIS_TID;
        for (int k = 0; k < int'(C_LANES); k++) prod_q[k] <= prod_c[k];
      end
    end
  end

  // Sign-extended sum of the registered lane products
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < int'(C_LANES); k++) begin
      sum_c = sum_c + C_ACC_WIDTH'($signed(prod_q[k]));
    end
  end

  // A TUSER beat restarts the dot product from its own sum
  assign acc_base_c = user1 ? '0 : acc_q;

`ifdef MAC_SATURATE_EN
  logic [C_ACC_WIDTH-1:0] acc_raw_c;
  logic                   ovf_c;

  // Clamp to the signed range when the final add overflows
  always_comb begin
    acc_raw_c  = acc_base_c + sum_c;
    ovf_c      = (acc_base_c[MSB] == sum_c[MSB]) && (acc_raw_c[MSB] != acc_base_c[MSB]);
    acc_next_c = acc_raw_c;
    if (ovf_c) begin
      acc_next_c = acc_base_c[MSB] ? {1'b1, {(C_ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(C_ACC_WIDTH-1){1'b1}}};
    end
  end
`else
  // Plain two's-complement wrap
  always_comb begin
    acc_next_c = acc_base_c + sum_c;
  end
`endif

  // Stage 2: accumulate, publish on last beat, retire the output on handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      acc_q          <= '0;
      MO_AXIS_TVALID <= 1'b0;
      MO_AXIS_TLAST  <= 1'b0;
      MO_AXIS_TDATA  <= '0;
      MO_AXIS_TID    <= '0;
    end else if (adv && v1 && last1) begin
      acc_q          <= '0;
      MO_AXIS_TVALID <= 1'b1;
      MO_AXIS_TLAST  <= 1'b1;
      MO_AXIS_TDATA  <= acc_next_c;
      MO_AXIS_TID    <= tid1;
    end else begin
      if (adv && v1) acc_q <= acc_next_c;
      if (MO_AXIS_TREADY) begin
        MO_AXIS_TVALID <= 1'b0;
        MO_AXIS_TLAST  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multilane_staged_mac.sv
// Bench for multilane_staged_mac: directed and random packets checked against a
// packet-level arithmetic model. A second instance with a 20-bit accumulator shares
// the stimulus to observe wrap / saturation.
module tb_multilane_staged_mac;

  localparam int AW   = 32;
  localparam int AW20 = 20;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        SD_AXIS_TREADY;
  logic [63:0] SD_AXIS_TDATA;
  logic        SD_AXIS_TLAST;
  logic        SD_AXIS_TUSER;
  logic        SD_AXIS_TVALID;
  logic [7:0]  SD_AXIS_TID;
  logic        MO_AXIS_TVALID;
  logic [31:0] MO_AXIS_TDATA;
  logic        MO_AXIS_TLAST;
  logic        MO_AXIS_TREADY;
  logic [7:0]  MO_AXIS_TID;

  logic        sd_tready20;
  logic        tvalid20;
  logic [19:0] tdata20;
  logic        tlast20;
  logic [7:0]  tid20;

  multilane_staged_mac #(.C_DATA_WIDTH(8), .C_LANES(4), .C_ACC_WIDTH(32), .C_TID_WIDTH(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .SD_AXIS_TREADY(SD_AXIS_TREADY), .SD_AXIS_TDATA(SD_AXIS_TDATA), .SD_AXIS_TLAST(SD_AXIS_TLAST),
    .SD_AXIS_TUSER(SD_AXIS_TUSER), .SD_AXIS_TVALID(SD_AXIS_TVALID), .SD_AXIS_TID(SD_AXIS_TID),
    .MO_AXIS_TVALID(MO_AXIS_TVALID), .MO_AXIS_TDATA(MO_AXIS_TDATA), .MO_AXIS_TLAST(MO_AXIS_TLAST),
    .MO_AXIS_TREADY(MO_AXIS_TREADY), .MO_AXIS_TID(MO_AXIS_TID));

  multilane_staged_mac #(.C_DATA_WIDTH(8), .C_LANES(4), .C_ACC_WIDTH(20), .C_TID_WIDTH(8)) dut20 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .SD_AXIS_TREADY(sd_tready20), .SD_AXIS_TDATA(SD_AXIS_TDATA), .SD_AXIS_TLAST(SD_AXIS_TLAST),
    .SD_AXIS_TUSER(SD_AXIS_TUSER), .SD_AXIS_TVALID(SD_AXIS_TVALID), .SD_AXIS_TID(SD_AXIS_TID),
    .MO_AXIS_TVALID(tvalid20), .MO_AXIS_TDATA(tdata20), .MO_AXIS_TLAST(tlast20),
    .MO_AXIS_TREADY(MO_AXIS_TREADY), .MO_AXIS_TID(tid20));

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  tid;
  } res_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          hold_err = 0;
  bit          rand_ready = 1'b0;
  res_t        exp_q[$];
  res_t        obs_q[$];
  logic [19:0] obs20_q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] held_data;
  logic [7:0]  held_tid;

  // Random output back-pressure when enabled
  always @(posedge ACLK) begin
    if (rand_ready) begin
      #1;
      MO_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    end
  end

  // Collect delivered results and watch that a stalled result holds still
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (!MO_AXIS_TVALID || MO_AXIS_TDATA !== held_data || MO_AXIS_TID !== held_tid))
        hold_err++;
      if (MO_AXIS_TVALID && MO_AXIS_TREADY) obs_q.push_back('{MO_AXIS_TDATA, MO_AXIS_TID});
      if (tvalid20 && MO_AXIS_TREADY) obs20_q.push_back(tdata20);
      stall_prev = MO_AXIS_TVALID && !MO_AXIS_TREADY;
      held_data  = MO_AXIS_TDATA;
      held_tid   = MO_AXIS_TID;
    end
  end

  // Reference: one accumulate step in a w-bit signed accumulator
  function automatic longint fold(longint a, longint s, int w);
    longint r  = a + s;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
`ifdef MAC_SATURATE_EN
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    r = r & ((longint'(1) <<< w) - 1);
    if (r > hi) r = r - (longint'(1) <<< w);
    if (r < lo) r = lo;
`endif
    return r;
  endfunction

  // Reference: dot product of one beat, byte k of ins/ws is lane k
  function automatic longint beat_sum(logic [31:0] ins, logic [31:0] ws);
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'($signed(ins[8*k +: 8])) * longint'($signed(ws[8*k +: 8]));
    return s;
  endfunction

  function automatic logic [63:0] pack(logic [31:0] ins, logic [31:0] ws);
    logic [63:0] d;
    for (int k = 0; k < 4; k++) begin
      d[16*k +: 8]     = ws[8*k +: 8];
      d[16*k + 8 +: 8] = ins[8*k +: 8];
    end
    return d;
  endfunction

  // Present one beat after an idle gap and hold it until accepted
  task automatic drive_beat(logic [31:0] ins, logic [31:0] ws, bit user, bit last, logic [7:0] tid, int gap);
    bit done = 1'b0;
    int n    = 0;
    repeat (gap) begin @(posedge ACLK); #1; end
    SD_AXIS_TDATA  = pack(ins, ws);
    SD_AXIS_TUSER  = user;
    SD_AXIS_TLAST  = last;
    SD_AXIS_TID    = tid;
    SD_AXIS_TVALID = 1'b1;
    while (!done) begin
      @(negedge ACLK);
      done = SD_AXIS_TREADY;
      @(posedge ACLK); #1;
      n++;
      if (!done && n > 2000) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: beat not accepted after %0d cycles, required acceptance", n);
        done = 1'b1;
      end
    end
    SD_AXIS_TVALID = 1'b0;
    SD_AXIS_TUSER  = 1'b0;
    SD_AXIS_TLAST  = 1'b0;
  endtask

  // Random packet; user_pos is the beat index carrying TUSER (-1 for none)
  task automatic send_packet(int nb, int user_pos, logic [7:0] tid, int gap_max);
    longint      acc = 0;
    logic [31:0] ins;
    logic [31:0] ws;
    int          g;
    for (int b = 0; b < nb; b++) begin
      ins = $urandom;
      ws  = $urandom;
      g   = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      if (b == user_pos) acc = 0;
      acc = fold(acc, beat_sum(ins, ws), AW);
      drive_beat(ins, ws, b == user_pos, b == nb - 1, tid, g);
    end
    exp_q.push_back('{32'(acc), tid});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 5000) begin @(posedge ACLK); n++; end
    repeat (5) @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; MO_AXIS_TREADY = 1'b0; SD_AXIS_TVALID = 1'b0; SD_AXIS_TDATA = '0;
    SD_AXIS_TUSER = 1'b0; SD_AXIS_TLAST = 1'b0; SD_AXIS_TID = '0;
    #12;
    n_tests++; if (SD_AXIS_TREADY !== 1'b0) begin n_fail++; $display("FAIL rst_sd_tready: got %b want 0", SD_AXIS_TREADY); end
    n_tests++; if (MO_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", MO_AXIS_TVALID); end
    n_tests++; if (MO_AXIS_TDATA !== 32'd0 || MO_AXIS_TID !== 8'd0 || MO_AXIS_TLAST !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: data=%h tid=%h last=%b want 0", MO_AXIS_TDATA, MO_AXIS_TID, MO_AXIS_TLAST); end
    @(posedge ACLK); #1;
    ARESETN = 1'b1; MO_AXIS_TREADY = 1'b1;
    n_tests++; if (SD_AXIS_TREADY !== 1'b0) begin n_fail++; $display("FAIL rst_release_early: got %b want 0", SD_AXIS_TREADY); end
    @(posedge ACLK); #1;
    n_tests++; if (SD_AXIS_TREADY !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", SD_AXIS_TREADY); end
  endtask

  task automatic test_basic();
    MO_AXIS_TREADY = 1'b1;
    drive_beat(32'h04030201, 32'h01010101, 1'b1, 1'b0, 8'h00, 0);
    drive_beat(32'hFFFFFFFF, 32'h02020202, 1'b0, 1'b1, 8'h5A, 0);
    n_tests++; if (MO_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL basic_early: tvalid %b want 0 one edge after accept", MO_AXIS_TVALID); end
    @(posedge ACLK); #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b1) begin n_fail++; $display("FAIL basic_latency: tvalid %b want 1", MO_AXIS_TVALID); end
    n_tests++; if (MO_AXIS_TDATA !== 32'h00000002) begin n_fail++; $display("FAIL basic_data: got %h want 00000002", MO_AXIS_TDATA); end
    n_tests++; if (MO_AXIS_TID !== 8'h5A || MO_AXIS_TLAST !== 1'b1) begin
      n_fail++; $display("FAIL basic_tid_last: tid=%h last=%b want 5a/1", MO_AXIS_TID, MO_AXIS_TLAST); end
    @(posedge ACLK); #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: tvalid %b want 0", MO_AXIS_TVALID); end
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL basic_count: got %0d results want 1", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    MO_AXIS_TREADY = 1'b0;
    drive_beat(32'h04030201, 32'h01010101, 1'b1, 1'b0, 8'h00, 0);
    drive_beat(32'hFFFFFFFF, 32'h02020202, 1'b0, 1'b1, 8'h5A, 0);
    exp_q.push_back('{32'd2, 8'h5A});
    @(posedge ACLK); #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b1 || SD_AXIS_TREADY !== 1'b0) begin
      n_fail++; $display("FAIL stall_ready_drop: tvalid=%b sd_tready=%b want 1/0", MO_AXIS_TVALID, SD_AXIS_TREADY); end
    fork
      for (int p = 0; p < 3; p++) send_packet(1 + int'($urandom_range(0, 3)), 0, 8'h10 + 8'(p), 0);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge ACLK);
          n_tests++;
          if (SD_AXIS_TREADY !== 1'b0 || MO_AXIS_TVALID !== 1'b1 || MO_AXIS_TDATA !== 32'd2) begin
            n_fail++; $display("FAIL stall_hold: cyc %0d sd_tready=%b tvalid=%b data=%h want 0/1/2", i, SD_AXIS_TREADY, MO_AXIS_TVALID, MO_AXIS_TDATA); end
        end
        @(posedge ACLK); #1;
        MO_AXIS_TREADY = 1'b1;
      end
    join
    wait_drain();
    n_tests++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (obs_q[i].data !== exp_q[i].data || obs_q[i].tid !== exp_q[i].tid) begin
        n_fail++; $display("FAIL stall_result %0d: got %h/%h want %h/%h", i, obs_q[i].data, obs_q[i].tid, exp_q[i].data, exp_q[i].tid); end
    end
    n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL stall_stability: %0d violations want 0", hold_err); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int beats = 0;
    int nb;
    int best = 0;
    int run  = 0;
    rand_ready = 1'b1;
    while (beats < 1000) begin
      nb = int'($urandom_range(1, 8));
      if (nb > 1000 - beats) nb = 1000 - beats;
      send_packet(nb, ($urandom_range(0, 1) == 0) ? 0 : -1, 8'($urandom), 2);
      beats += nb;
    end
    rand_ready = 1'b0;
    @(posedge ACLK); #2;
    MO_AXIS_TREADY = 1'b1;
    wait_drain();
    n_tests++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (obs_q[i].data !== exp_q[i].data || obs_q[i].tid !== exp_q[i].tid) begin
        n_fail++; $display("FAIL rand_result %0d: got %h/%h want %h/%h", i, obs_q[i].data, obs_q[i].tid, exp_q[i].data, exp_q[i].tid); end
    end
    n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL rand_stability: %0d violations want 0", hold_err); end
    obs_q.delete(); exp_q.delete();
    // back-to-back single-beat packets must give an unbroken run of results
    fork
      for (int p = 0; p < 8; p++) send_packet(1, 0, 8'hB0 + 8'(p), 0);
      repeat (24) begin
        @(negedge ACLK);
        if (MO_AXIS_TVALID && MO_AXIS_TREADY) begin run++; if (run > best) best = run; end
        else run = 0;
      end
    join
    wait_drain();
    n_tests++; if (best !== 8) begin n_fail++; $display("FAIL b2b_run: longest result run %0d want 8", best); end
    n_tests++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++; if (obs_q[i].data !== exp_q[i].data || obs_q[i].tid !== exp_q[i].tid) begin
        n_fail++; $display("FAIL b2b_result %0d: got %h/%h want %h/%h", i, obs_q[i].data, obs_q[i].tid, exp_q[i].data, exp_q[i].tid); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    longint acc32 = 0;
    longint acc20 = 0;
    MO_AXIS_TREADY = 1'b1;
    obs20_q.delete();
    for (int b = 0; b < 200; b++) begin
      acc32 = fold(acc32, beat_sum(32'h80808080, 32'h80808080), AW);
      acc20 = fold(acc20, beat_sum(32'h80808080, 32'h80808080), AW20);
      drive_beat(32'h80808080, 32'h80808080, b == 0, b == 199, 8'hC4, 0);
    end
    exp_q.push_back('{32'(acc32), 8'hC4});
    wait_drain();
    n_tests++; if (obs_q.size() !== 1 || obs_q[0].data !== exp_q[0].data) begin
      n_fail++; $display("FAIL wrap_acc32: got %0d results first %h want %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 32'hx, exp_q[0].data); end
    n_tests++; if (obs20_q.size() !== 1 || obs20_q[0] !== 20'(acc20)) begin
      n_fail++; $display("FAIL wrap_acc20: got %0d results first %h want %h", obs20_q.size(), (obs20_q.size() > 0) ? obs20_q[0] : 20'hx, 20'(acc20)); end
    obs_q.delete(); exp_q.delete(); obs20_q.delete();
  endtask

  task automatic test_reset_mid();
    // pending result dropped by reset
    MO_AXIS_TREADY = 1'b0;
    send_packet(2, 0, 8'h33, 0);
    exp_q.delete();
    repeat (2) @(posedge ACLK); #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: tvalid %b want 1", MO_AXIS_TVALID); end
    ARESETN = 1'b0; #1;
    n_tests++; if (MO_AXIS_TVALID !== 1'b0 || MO_AXIS_TDATA !== 32'd0 || MO_AXIS_TID !== 8'd0 || MO_AXIS_TLAST !== 1'b0 || SD_AXIS_TREADY !== 1'b0) begin
      n_fail++; $display("FAIL rmid_clear1: tvalid=%b data=%h tid=%h last=%b sd_tready=%b want all 0", MO_AXIS_TVALID, MO_AXIS_TDATA, MO_AXIS_TID, MO_AXIS_TLAST, SD_AXIS_TREADY); end
    @(posedge ACLK); #1;
    ARESETN = 1'b1; MO_AXIS_TREADY = 1'b1;
    @(posedge ACLK); #1;
    // partial sum dropped by reset
    drive_beat($urandom, $urandom, 1'b1, 1'b0, 8'h44, 0);
    drive_beat($urandom, $urandom, 1'b0, 1'b0, 8'h44, 0);
    ARESETN = 1'b0; #1;
    n_tests++; if (SD_AXIS_TREADY !== 1'b0 || MO_AXIS_TVALID !== 1'b0) begin
      n_fail++; $display("FAIL rmid_clear2: sd_tready=%b tvalid=%b want 0/0", SD_AXIS_TREADY, MO_AXIS_TVALID); end
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    n_tests++; if (SD_AXIS_TREADY !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_early: got %b want 0", SD_AXIS_TREADY); end
    @(posedge ACLK); #1;
    n_tests++; if (SD_AXIS_TREADY !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_back: got %b want 1", SD_AXIS_TREADY); end
    send_packet(3, -1, 8'h77, 1);
    wait_drain();
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", obs_q.size()); end
    n_tests++; if (obs_q.size() > 0 && (obs_q[0].data !== exp_q[0].data || obs_q[0].tid !== exp_q[0].tid)) begin
      n_fail++; $display("FAIL rmid_result: got %h/%h want %h/%h", obs_q[0].data, obs_q[0].tid, exp_q[0].data, exp_q[0].tid); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_user_mid();
    MO_AXIS_TREADY = 1'b1;
    send_packet(5, 2, 8'h66, 1);
    wait_drain();
    n_tests++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL umid_count: got %0d want 1", obs_q.size()); end
    n_tests++; if (obs_q.size() > 0 && (obs_q[0].data !== exp_q[0].data || obs_q[0].tid !== exp_q[0].tid)) begin
      n_fail++; $display("FAIL umid_result: got %h/%h want %h/%h", obs_q[0].data, obs_q[0].tid, exp_q[0].data, exp_q[0].tid); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_wrap();
    test_reset_mid();
    test_user_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
